risc_dmem_responder: RTL and testbench

//  Data-memory responder that serves the pipeline's memory-stage load/store requests over a valid/ready handshake.

---
 rtl/risc_dmem_responder.sv | 119 +++++++++++
 tb/tb_risc_dmem_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/risc_dmem_responder.sv
// Data-memory responder for the memory stage. It accepts one load or store over a valid/ready
// handshake, waits WAIT_CYCLES cycles, then presents a registered response for one cycle.
module risc_dmem_responder #(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic             req_we,
   input  logic [31:0]      req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             req_ready,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err,
   output logic             busy
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t state, stateNext;
   logic [3:0] cnt, cntNext;
   logic accept, access;

   logic             latWe;
   logic [31:0]      latAddr;
   logic [WIDTH-1:0] latWdata;

   logic             accWe;
   logic [31:0]      accAddr;
   logic [WIDTH-1:0] accWdata;
   logic             accErr;
   logic [IDX_W-1:0] accIdx;

   logic [WIDTH-1:0] mem [DEPTH];

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      accept    = 1'b0;
      access    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  access    = 1'b1;
                  stateNext = ST_RESP;
               end else begin
                  cntNext   = 4'(WAIT_CYCLES - 1);
                  stateNext = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt != 4'd0) begin
               cntNext = cnt - 4'd1;
            end else begin
               access    = 1'b1;
               stateNext = ST_RESP;
            end
         end
         ST_RESP: stateNext = ST_IDLE;
         default: stateNext = ST_IDLE;
      endcase
   end

   // With zero wait states the access happens on the accept edge, so the live inputs are used.
   assign accWe    = (state == ST_IDLE) ? req_we    : latWe;
   assign accAddr  = (state == ST_IDLE) ? req_addr  : latAddr;
   assign accWdata = (state == ST_IDLE) ? req_wdata : latWdata;
   assign accErr   = (accAddr[1:0] != 2'b00) || (accAddr[31:2] >= 30'(DEPTH));
   assign accIdx   = accAddr[IDX_W+1:2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         latWe      <= 1'b0;
         latAddr    <= '0;
         latWdata   <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
         if (accept) begin
            latWe    <= req_we;
            latAddr  <= req_addr;
            latWdata <= req_wdata;
         end
         if (access) begin
            resp_err   <= accErr;
            resp_rdata <= (accErr || accWe) ? '0 : mem[accIdx];
         end
      end
   end

   // Storage is never cleared, but the write sits under the reset branch so an aborted store cannot land.
   always_ff @(posedge clk or posedge rst) begin
      if (!rst) begin
         if (access && accWe && !accErr)
            mem[accIdx] <= accWdata;
      end
   end

   assign req_ready  = (state == ST_IDLE);
   assign resp_valid = (state == ST_RESP);
   assign busy       = ((state == ST_IDLE) && req_valid) || (state == ST_WAIT);

endmodule

// File: tb/tb_risc_dmem_responder.sv
// Bench for risc_dmem_responder: a WAIT_CYCLES=2 instance driven from a vector table through a
// response scoreboard, and a WAIT_CYCLES=0 instance exercised with back-to-back requests.
module tb_risc_dmem_responder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        reqValid, reqWe, reqReady, respValid, respErr, busy;
   logic [31:0] reqAddr, reqWdata, respRdata;

   logic        reqValid0, reqWe0, reqReady0, respValid0, respErr0, busy0;
   logic [31:0] reqAddr0, reqWdata0, respRdata0;

   risc_dmem_responder #(.WIDTH(32), .DEPTH(64), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(reqValid), .req_we(reqWe), .req_addr(reqAddr), .req_wdata(reqWdata),
      .req_ready(reqReady), .resp_valid(respValid), .resp_rdata(respRdata),
      .resp_err(respErr), .busy(busy)
   );

   risc_dmem_responder #(.WIDTH(32), .DEPTH(64), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(reqValid0), .req_we(reqWe0), .req_addr(reqAddr0), .req_wdata(reqWdata0),
      .req_ready(reqReady0), .resp_valid(respValid0), .resp_rdata(respRdata0),
      .resp_err(respErr0), .busy(busy0)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] expRdata;
      logic        expErr;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acceptCyc;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[13];
   int   nCompared = 0;
   int   nFail = 0;
   int   cyc = 0;
   logic chkLow = 1'b0;
   exp_t e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response monitor for the WAIT_CYCLES=2 instance.
   always @(negedge clk) begin
      if (chkLow) check("resp_pulse_width", 32'(respValid), 32'd0);
      chkLow = respValid;
      if (respValid) begin
         check("resp_expected", 32'(sb.size() != 0), 32'd1);
         check("busy_in_resp", 32'(busy), 32'd0);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("resp_rdata", respRdata, e.rdata);
            check("resp_err", 32'(respErr), 32'(e.err));
            check("resp_latency", 32'(cyc - e.acceptCyc), 32'd3);
         end
      end
   end

   // Called just after a negedge; returns just after a negedge once the response has been consumed.
   task automatic issue(input vec_t v);
      int unsigned n;
      reqValid = 1'b1;
      reqWe    = v.we;
      reqAddr  = v.addr;
      reqWdata = v.wdata;
      #1;
      n = 0;
      while (!reqReady && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!reqReady) begin
         check("accept_timeout", 32'(reqReady), 32'd1);
         reqValid = 1'b0;
         return;
      end
      check("busy_idle_req", 32'(busy), 32'd1);
      sb.push_back('{v.expRdata, v.expErr, cyc});
      @(negedge clk);
      reqValid = 1'b0;
      reqWe    = ~v.we;
      reqAddr  = $urandom;
      reqWdata = $urandom;
      #1;
      check("busy_in_wait", 32'(busy), 32'd1);
      check("ready_in_wait", 32'(reqReady), 32'd0);
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         check("resp_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
      vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 32'h0,         1'b0};
      vecs[3]  = '{1'b0, 32'h0000_0102, 32'h0,         32'h0,         1'b1};
      vecs[4]  = '{1'b0, 32'h0000_0012, 32'h0,         32'h0,         1'b1};
      vecs[5]  = '{1'b1, 32'h0000_0100, 32'hBAD0_BAD0, 32'h0,         1'b1};
      vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h1234_5678, 1'b0};
      vecs[7]  = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 32'h0,         1'b0};
      vecs[8]  = '{1'b0, 32'h0000_00FC, 32'h0,         32'hCAFE_F00D, 1'b0};
      vecs[9]  = '{1'b1, 32'h0000_0011, 32'h5555_5555, 32'h0,         1'b1};
      vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1};
      vecs[12] = '{1'b0, 32'h0000_00FC, 32'h0,         32'hCAFE_F00D, 1'b0};

      rst = 1'b1;
      reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqWdata = '0;
      reqValid0 = 1'b0; reqWe0 = 1'b0; reqAddr0 = '0; reqWdata0 = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("rst_ready", 32'(reqReady), 32'd1);
      check("rst_resp_valid", 32'(respValid), 32'd0);
      check("rst_rdata", respRdata, 32'd0);
      check("rst_err", 32'(respErr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst0_ready", 32'(reqReady0), 32'd1);
      check("rst0_rdata", respRdata0, 32'd0);

      for (int i = 0; i < 13; i++) issue(vecs[i]);

      // Reset aborting a store during its wait states.
      issue('{1'b1, 32'h0000_0020, 32'h1111_2222, 32'h0, 1'b0});
      issue('{1'b0, 32'h0000_0020, 32'h0, 32'h1111_2222, 1'b0});
      reqValid = 1'b1; reqWe = 1'b1; reqAddr = 32'h20; reqWdata = 32'h9999_9999;
      @(negedge clk);
      reqValid = 1'b0;
      check("abort_in_wait", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_resp_valid", 32'(respValid), 32'd0);
      check("abort_rdata", respRdata, 32'd0);
      check("abort_err", 32'(respErr), 32'd0);
      check("abort_ready", 32'(reqReady), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      issue('{1'b0, 32'h0000_0020, 32'h0, 32'h1111_2222, 1'b0});

      // Zero wait states, request held continuously.
      for (int i = 0; i < 10; i++) begin
         reqValid0 = 1'b1; reqWe0 = 1'b1; reqAddr0 = 32'h4;
         reqWdata0 = 32'hA000_0000 + 32'(i);
         #1;
         check("b2b_ready", 32'(reqReady0), 32'((i % 2) == 0));
         check("b2b_busy", 32'(busy0), 32'((i % 2) == 0));
         check("b2b_resp_valid", 32'(respValid0), 32'((i % 2) == 1));
         if ((i % 2) == 1) begin
            check("b2b_rdata", respRdata0, 32'd0);
            check("b2b_err", 32'(respErr0), 32'd0);
         end
         @(negedge clk);
      end
      reqValid0 = 1'b0;
      #1;
      check("b2b_idle_busy", 32'(busy0), 32'd0);
      check("b2b_idle_ready", 32'(reqReady0), 32'd1);
      @(negedge clk);
      reqValid0 = 1'b1; reqWe0 = 1'b0; reqAddr0 = 32'h4;
      #1;
      check("w0_load_busy", 32'(busy0), 32'd1);
      @(negedge clk);
      reqValid0 = 1'b0;
      #1;
      check("w0_load_valid", 32'(respValid0), 32'd1);
      check("w0_load_rdata", respRdata0, 32'hA000_0008);
      check("w0_load_err", 32'(respErr0), 32'd0);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, compared %0d", nCompared);
      $fatal(1);
   end

endmodule
